// File: rtl/inst_fifo_assembler_if.sv
// Word-in / instruction-out handshake bundle for the instruction FIFO assembler.
// The slave view belongs to the assembler and the master view to its environment.
// Widths are fixed by the command word (32) and the decoder instruction (83).
interface inst_fifo_assembler_if;
  logic [31:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic [82:0] inst_out;
  logic        inst_valid;
  logic        inst_read;

  // Environment view: drives command words and pops instructions.
  modport master (
    output word_in,
    output word_valid,
    output inst_read,
    input  word_ready,
    input  inst_out,
    input  inst_valid
  );

  // Assembler view.
  modport slave (
    input  word_in,
    input  word_valid,
    input  inst_read,
    output word_ready,
    output inst_out,
    output inst_valid
  );
endinterface

// File: rtl/inst_fifo_assembler.sv
// Assembles 32-bit command words into 83-bit instructions and queues them for the decoder.
// Latency: instruction visible one cycle after its final word is accepted.
// Backpressure: word_ready = !full from registered count; a pop frees space only from the next cycle.
module inst_fifo_assembler #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               clear,
  inst_fifo_assembler_if.slave bus,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  // W0: expecting the first word of an instruction.
  // W1/W2: second/third word of a draw instruction.
  typedef enum logic [1:0] {
    W0 = 2'd0,
    W1 = 2'd1,
    W2 = 2'd2
  } asm_state_t;

  asm_state_t       state;
  logic [63:0]      shadow;
  logic [82:0]      mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  logic             accept;
  logic             push;
  logic             pop;
  logic [82:0]      push_data;

  // Status flags come straight from the registered count, so the word-side
  // ready never depends on word_in and a same-cycle pop cannot open a slot.
  assign full           = (count == DEPTH_CNT);
  assign empty          = (count == '0);
  assign bus.word_ready = !full;
  assign bus.inst_valid = !empty;

  // Head entry is forced to zero while empty so the reset-time output is
  // deterministic even though the storage itself is never reset.
  assign bus.inst_out   = empty ? '0 : mem[rd_ptr];

  // A word accepted in a clear cycle is discarded along with everything else.
  assign accept = bus.word_valid && !full && !clear;
  assign pop    = bus.inst_read && !empty && !clear;

  // Decide whether the accepted word completes an instruction, and build it.
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    if (accept) begin
      case (state)
        W0: begin
          if (bus.word_in[0]) begin
            push      = 1'b1;
            push_data = {79'b0, bus.word_in[3:0]};
          end
        end
        W2: begin
          push      = 1'b1;
          push_data = {bus.word_in[18:0], shadow};
        end
        default: begin
        end
      endcase
    end
  end

  // Assembler FSM: collects the first two draw words in the shadow register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state  <= W0;
      shadow <= '0;
    end else if (clear) begin
      state  <= W0;
      shadow <= '0;
    end else if (accept) begin
      case (state)
        W0: begin
          if (!bus.word_in[0]) begin
            shadow[31:0] <= bus.word_in;
            state        <= W1;
          end
        end
        W1: begin
          shadow[63:32] <= bus.word_in;
          state         <= W2;
        end
        W2: begin
          state <= W0;
        end
        default: begin
          state <= W0;
        end
      endcase
    end
  end

  // Queue pointers and occupancy; clear beats any push or pop in the same cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Instruction storage, written on the accepting edge; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule
